// File: rtl/megasys_vram_arbiter.sv
// ---------------------------------------------------------------------------
// megasys_vram_arbiter
//
// Shares one single-port video RAM between three requesters. The requesters
// are background tile fetch (bg), sprite fetch (spr) and CPU. Read data is
// routed back through a fixed-latency tag pipeline.
//
// Window-dependent priority, evaluated combinationally every cycle:
//   active display (hbl|vbl = 0) : bg  > spr > cpu
//   blanking       (hbl|vbl = 1) : cpu > spr > bg
//
// Optional build macro VRAM_ARB_STARVE_EN:
//   A saturating counter counts the active-window cycles in which the CPU
//   waits. At STARVE_MAX the CPU is promoted to top priority
//   (cpu > bg > spr) until its next ack.
//   Without the macro, only strict window priority applies.
//
// Parameters:
//   AW          address width
//   DW          data width
//   RD_LAT      RAM read latency, registered ram_cs -> valid ram_dout (>= 1)
//   STARVE_MAX  CPU wait cycles before the forced grant (macro builds only)
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   hbl, vbl                      blanking flags from the timing generator
//   bg_req/addr/ack/valid         tile fetch port (read-only)
//   spr_req/addr/ack/valid        sprite fetch port (read-only)
//   cpu_req/we/addr/din/ack/valid CPU port (read/write)
//   rd_data                       shared read data, qualified by *_valid
//   ram_cs/we/addr/din            registered RAM command
//   ram_dout                      RAM read data
// ---------------------------------------------------------------------------
module megasys_vram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hbl,
  input  logic          vbl,
  input  logic          bg_req,
  input  logic [AW-1:0] bg_addr,
  output logic          bg_ack,
  output logic          bg_valid,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_ack,
  output logic          spr_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic          cpu_valid,
  output logic [DW-1:0] rd_data,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    SRC_BG  = 2'd0,
    SRC_SPR = 2'd1,
    SRC_CPU = 2'd2
  } src_e;

  typedef struct packed {
    logic live;
    src_e src;
  } tag_t;

  logic blank;
  logic cpu_promote;
  logic gnt_bg, gnt_spr, gnt_cpu;

  assign blank = hbl | vbl;

  // -------------------------------------------------------------------------
  // Grant selection. Acks are gated by reset_n so nothing is granted while
  // the block is held in reset.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path can leave it unassigned and infer a latch.
    gnt_bg  = 1'b0;
    gnt_spr = 1'b0;
    gnt_cpu = 1'b0;
    if (reset_n) begin
      if (cpu_req && (blank || cpu_promote)) begin
        gnt_cpu = 1'b1;
      end else if (blank) begin
        if (spr_req)     gnt_spr = 1'b1;
        else if (bg_req) gnt_bg  = 1'b1;
      end else begin
        if (bg_req)       gnt_bg  = 1'b1;
        else if (spr_req) gnt_spr = 1'b1;
        else if (cpu_req) gnt_cpu = 1'b1;
      end
    end
  end

  assign bg_ack  = gnt_bg;
  assign spr_ack = gnt_spr;
  assign cpu_ack = gnt_cpu;

  // -------------------------------------------------------------------------
  // CPU starvation guard
  // -------------------------------------------------------------------------
`ifdef VRAM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || gnt_cpu) begin
      starve_cnt_d = '0;
    end else if (!blank && (starve_cnt_q != SW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  assign cpu_promote = (starve_cnt_q == SW'(STARVE_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_cnt_q <= '0;
    else          starve_cnt_q <= starve_cnt_d;
  end
`else
  // The starvation threshold has no effect in this build; the CPU is never
  // promoted.
  assign cpu_promote = (STARVE_MAX < 0);
`endif

  // -------------------------------------------------------------------------
  // Registered RAM command. Address and data hold when there is no grant.
  // -------------------------------------------------------------------------
  logic          ram_cs_q,   ram_cs_d;
  logic          ram_we_q,   ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q,  ram_din_d;

  always_comb begin
    ram_cs_d   = gnt_bg | gnt_spr | gnt_cpu;
    ram_we_d   = gnt_cpu & cpu_we;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (gnt_bg)  ram_addr_d = bg_addr;
    if (gnt_spr) ram_addr_d = spr_addr;
    if (gnt_cpu) begin
      ram_addr_d = cpu_addr;
      ram_din_d  = cpu_din;
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline. Stage k holds the tag of the access whose ram_cs was
  // k cycles ago. Stage RD_LAT lines up with valid ram_dout.
  // -------------------------------------------------------------------------
  tag_t          push_tag;
  tag_t [RD_LAT:0] tag_q, tag_d;
  tag_t          tag_out;
  logic [2:0]    valid_q, valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  always_comb begin
    push_tag.live = (gnt_bg | gnt_spr | gnt_cpu) & ~(gnt_cpu & cpu_we);
    push_tag.src  = gnt_cpu ? SRC_CPU : (gnt_spr ? SRC_SPR : SRC_BG);
    tag_d         = {tag_q[RD_LAT-1:0], push_tag};
  end

  assign tag_out = tag_q[RD_LAT];

  always_comb begin
    valid_d   = '0;
    rd_data_d = rd_data_q;
    if (tag_out.live) begin
      rd_data_d = ram_dout;
      case (tag_out.src)
        SRC_BG:  valid_d[0] = 1'b1;
        SRC_SPR: valid_d[1] = 1'b1;
        SRC_CPU: valid_d[2] = 1'b1;
        default: valid_d    = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      // NOTE: the tag pipeline is a small flop array, not a memory, and it is
      // reset on purpose: clearing it drops in-flight reads so that no valid
      // pulse follows reset release.
      tag_q      <= '0;
      valid_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign bg_valid  = valid_q[0];
  assign spr_valid = valid_q[1];
  assign cpu_valid = valid_q[2];
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_megasys_vram_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for megasys_vram_arbiter.
// Contains a RAM model with RD_LAT read latency.
// A cycle monitor compares every cycle against a reference model. The model
// works from the rule set: a priority order list per window, a shadow
// memory, and a return queue with due cycles.
// The bench runs table vectors, hand sequences for the corner cases, and a
// randomized phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_megasys_vram_arbiter;

  localparam int AW         = 16;
  localparam int DW         = 16;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;
  localparam int RET_LAT    = RD_LAT + 2;  // ack -> valid

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          hbl = 1'b0, vbl = 1'b0;
  logic          bg_req = 1'b0, spr_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] bg_addr = '0, spr_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic          bg_ack, spr_ack, cpu_ack, bg_valid, spr_valid, cpu_valid;
  logic [DW-1:0] rd_data, ram_din, ram_dout;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  megasys_vram_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hbl(hbl), .vbl(vbl),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_valid(bg_valid),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_valid(spr_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .rd_data(rd_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  logic [2:0] acks, valids;
  assign acks   = {cpu_ack, spr_ack, bg_ack};
  assign valids = {cpu_valid, spr_valid, bg_valid};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a * 16'h9E37) ^ 16'hA5C3;
  endfunction

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram_mem [0:65535];
  logic [DW-1:0] ram_pipe [RD_LAT];
  assign ram_dout = ram_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_din;
    ram_pipe[0] <= (ram_cs && !ram_we) ? ram_mem[ram_addr] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  // ---------------- reference model / monitor ----------------
  typedef struct {
    int            src;
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  ret_t          ret_q[$];
  logic [DW-1:0] shadow [0:65535];
  int            cyc = 0;
  int            starve_cnt = 0;
  logic          prev_gnt = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;
  logic [2:0]    m_g, m_ev;
  logic          m_prom;

  always @(posedge clk) cyc <= cyc + 1;

  // First requester in the window's order list that is requesting wins.
  function automatic logic [2:0] ref_grant(input logic blank_w, input logic promote,
                                           input logic [2:0] reqs);
    int order[3];
    if (promote && reqs[2]) order = '{2, 0, 1};
    else if (blank_w)       order = '{2, 1, 0};
    else                    order = '{0, 1, 2};
    for (int k = 0; k < 3; k++)
      if (reqs[order[k]]) return 3'(1 << order[k]);
    return 3'b000;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_ack", 32'(acks), 32'd0);
      check("rst_valid", 32'(valids), 32'd0);
      check("rst_ram_cs_we", {30'd0, ram_cs, ram_we}, 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_din", 32'(ram_din), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      ret_q.delete();
      starve_cnt = 0;
      prev_gnt   = 1'b0;
      prev_we    = 1'b0;
      exp_addr   = '0;
      exp_din    = '0;
    end else begin
      // RAM command issued for last cycle's grant
      check("ram_cs", 32'(ram_cs), 32'(prev_gnt));
      check("ram_we", 32'(ram_we), 32'(prev_we));
      check("ram_addr", 32'(ram_addr), 32'(exp_addr));
      check("ram_din", 32'(ram_din), 32'(exp_din));
      // read returns
      m_ev = 3'b000;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        m_ev = 3'(1 << ret_q[0].src);
        check("rd_data", 32'(rd_data), 32'(ret_q[0].data));
        void'(ret_q.pop_front());
      end
      check("valid", 32'(valids), 32'(m_ev));
      // grant
`ifdef VRAM_ARB_STARVE_EN
      m_prom = (starve_cnt >= STARVE_MAX);
`else
      m_prom = 1'b0;
`endif
      m_g = ref_grant(hbl | vbl, m_prom, {cpu_req, spr_req, bg_req});
      check("ack", 32'(acks), 32'(m_g));
      prev_gnt = |m_g;
      prev_we  = m_g[2] & cpu_we;
      if (m_g[0]) begin
        exp_addr = bg_addr;
        ret_q.push_back('{0, shadow[bg_addr], cyc + RET_LAT});
      end
      if (m_g[1]) begin
        exp_addr = spr_addr;
        ret_q.push_back('{1, shadow[spr_addr], cyc + RET_LAT});
      end
      if (m_g[2]) begin
        exp_addr = cpu_addr;
        exp_din  = cpu_din;
        if (cpu_we) shadow[cpu_addr] = cpu_din;
        else ret_q.push_back('{2, shadow[cpu_addr], cyc + RET_LAT});
      end
`ifdef VRAM_ARB_STARVE_EN
      if (!cpu_req || m_g[2])                             starve_cnt = 0;
      else if (!(hbl | vbl) && starve_cnt < STARVE_MAX)   starve_cnt++;
`endif
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic       hbl, vbl, bg, spr, cpu;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc, k, found, seen;
    logic [2:0] last_ack;

    // table: {hbl, vbl, bg, spr, cpu, expected {cpu,spr,bg} ack}
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010};

    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = init_val(AW'(i));
      shadow[i]  = init_val(AW'(i));
    end
    for (int i = 0; i < RD_LAT; i++) ram_pipe[i] = '0;

    // ---- reset with all requests high ----
    #1 reset_n = 1'b0;
    bg_req = 1'b1; spr_req = 1'b1; cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("reset_outputs", {24'd0, acks, valids, ram_cs, ram_we}, 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    step();
    idle_reqs();
    bg_req = 1'b1; bg_addr = 16'h0010; reset_n = 1'b1;
    #2;
    check("first_bg_ack", 32'(acks), 32'b001);
    ack_cyc = cyc;
    step();
    bg_req = 1'b0;
    #2;
    check("first_ram_cs", 32'(ram_cs), 32'd1);
    check("first_ram_addr", 32'(ram_addr), 32'h0010);
    while (cyc < ack_cyc + RET_LAT - 1) step();
    #2;
    check("first_bg_valid_early", 32'(bg_valid), 32'd0);
    step();
    #2;
    check("first_bg_valid", 32'(bg_valid), 32'd1);
    check("first_rd_data", 32'(rd_data), 32'(init_val(16'h0010)));

    // ---- table-driven priority vectors ----
    for (int i = 0; i < 10; i++) begin
      step();
      {hbl, vbl, bg_req, spr_req, cpu_req} = {vecs[i].hbl, vecs[i].vbl,
                                              vecs[i].bg, vecs[i].spr, vecs[i].cpu};
      cpu_we = 1'b0;
      bg_addr = AW'(16'h0100 + i); spr_addr = AW'(16'h0140 + i); cpu_addr = AW'(16'h0180 + i);
      #2;
      check($sformatf("table_%0d", i), 32'(acks), 32'(vecs[i].exp));
    end
    step(); idle_reqs(); hbl = 1'b0; vbl = 1'b0;

    // ---- priority flip within a cycle ----
    step();
    bg_req = 1'b1; spr_req = 1'b1; cpu_req = 1'b1; hbl = 1'b0;
    #2 check("flip_active_bg", 32'(acks), 32'b001);
    step(); hbl = 1'b1;
    #2 check("flip_blank_cpu", 32'(acks), 32'b100);
    step(); cpu_req = 1'b0;
    #2 check("flip_blank_spr", 32'(acks), 32'b010);
    step(); spr_req = 1'b0;
    #2 check("flip_blank_bg", 32'(acks), 32'b001);
    step(); idle_reqs(); hbl = 1'b0;

    // ---- CPU write then read back ----
    step();
    hbl = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_din = 16'hBEEF;
    #2 check("wr_ack", 32'(acks), 32'b100);
    step(); idle_reqs();
    #2;
    check("wr_ram_cs_we", {30'd0, ram_cs, ram_we}, 32'b11);
    check("wr_ram_din", 32'(ram_din), 32'hBEEF);
    check("wr_ram_addr", 32'(ram_addr), 32'h1234);
    step(); cpu_req = 1'b1; cpu_we = 1'b0;
    #2 check("rd_ack", 32'(acks), 32'b100);
    ack_cyc = cyc;
    seen = 0;
    for (int i = 1; i < RET_LAT; i++) begin
      step(); idle_reqs();
      #2 if (cpu_valid) seen++;
    end
    check("wr_no_cpu_valid", 32'(seen), 32'd0);
    step();
    #2;
    check("rd_cpu_valid", 32'(cpu_valid), 32'd1);
    check("rd_back_data", 32'(rd_data), 32'hBEEF);
    hbl = 1'b0;

    // ---- back-to-back bg/spr interleave ----
    for (int i = 0; i < 16 + RET_LAT; i++) begin
      step();
      if (i < 16) begin
        bg_req  = (i % 2 == 0);
        spr_req = (i % 2 == 1);
        bg_addr = AW'(16'h0200 + i); spr_addr = AW'(16'h0200 + i);
      end else begin
        idle_reqs();
      end
      #2;
      if (i < 16) check($sformatf("ilv_ack_%0d", i), 32'(acks), (i % 2 == 0) ? 32'b001 : 32'b010);
      if (i >= RET_LAT) begin
        check($sformatf("ilv_valid_%0d", i - RET_LAT), 32'(valids),
              ((i - RET_LAT) % 2 == 0) ? 32'b001 : 32'b010);
        check($sformatf("ilv_data_%0d", i - RET_LAT), 32'(rd_data),
              32'(init_val(AW'(16'h0200 + i - RET_LAT))));
      end
    end

    // ---- CPU starvation during active display ----
    step();
    hbl = 1'b0; bg_req = 1'b1; bg_addr = 16'h0300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    found = 0; k = 0;
    for (int i = 1; i <= 30 && found == 0; i++) begin
      if (i > 1) step();
      #2;
      if (cpu_ack) begin found = 1; k = i; end
    end
`ifdef VRAM_ARB_STARVE_EN
    check("starve_first_ack_cycle", 32'(k), 32'(STARVE_MAX + 1));
    found = 0; k = 0;
    for (int i = 1; i <= 30 && found == 0; i++) begin
      step();
      #2;
      if (cpu_ack) begin found = 1; k = i; end
    end
    check("starve_restart_ack_cycle", 32'(k), 32'(STARVE_MAX + 1));
`else
    check("no_starve_ack", 32'(found), 32'd0);
    step(); hbl = 1'b1;
    #2 check("blank_cpu_ack", 32'(acks), 32'b100);
`endif
    step(); idle_reqs(); hbl = 1'b0;
    repeat (RET_LAT + 1) step();

    // ---- reset while a bg read is in flight ----
    bg_req = 1'b1; bg_addr = 16'h0050;
    #2 check("mid_rst_ack", 32'(acks), 32'b001);
    step(); idle_reqs();
    step(); reset_n = 1'b0;
    step();
    step(); reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      #2 if (valids != 3'b000) seen++;
      step();
    end
    check("mid_rst_no_valid", 32'(seen), 32'd0);

    // ---- randomized traffic ----
    last_ack = 3'b000;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!bg_req || last_ack[0]) begin
        bg_req = ($urandom_range(0, 99) < 60); bg_addr = AW'($urandom_range(0, 63));
      end else if ($urandom_range(0, 99) < 5) bg_req = 1'b0;
      if (!spr_req || last_ack[1]) begin
        spr_req = ($urandom_range(0, 99) < 50); spr_addr = AW'($urandom_range(0, 63));
      end else if ($urandom_range(0, 99) < 5) spr_req = 1'b0;
      if (!cpu_req || last_ack[2]) begin
        cpu_req  = ($urandom_range(0, 99) < 50);
        cpu_we   = ($urandom_range(0, 99) < 35);
        cpu_addr = AW'($urandom_range(0, 63));
        cpu_din  = DW'($urandom);
      end else if ($urandom_range(0, 99) < 5) cpu_req = 1'b0;
      if ($urandom_range(0, 15) == 0) hbl = ~hbl;
      if ($urandom_range(0, 63) == 0) vbl = ~vbl;
      #2 last_ack = acks;
    end

    step(); idle_reqs(); hbl = 1'b0; vbl = 1'b0;
    repeat (RET_LAT + 2) step();
    check("drain_queue_empty", 32'(ret_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
